// File: rtl/ts_pkg.sv
// Shared types and constants for the event timestamp capture blocks.
package ts_pkg;

    localparam int TS_W       = 64;
    localparam int CH_W_MAX   = 3;
    localparam int NCH_MIN    = 1;
    localparam int NCH_MAX    = 8;
    localparam int DEPTH_MIN  = 2;
    localparam int DEPTH_MAX  = 64;
    localparam int DROP_CNT_W = 16;

    // Queue entry: channel index sized for the largest legal NCH.
    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic [TS_W-1:0]     ts;
    } ts_entry_t;

endpackage

// File: rtl/ts_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/count.
// A push into an empty FIFO becomes visible at the head on the next cycle.
module ts_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        dout     = empty ? '0 : mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/event_timestamp_capture.sv
// Latches the microsecond count on rising edges of asynchronous event inputs and
// queues {channel, stamp}. Define TS_DROP_CNT_EN to add the saturating DROP_CNT.
module event_timestamp_capture
    import ts_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  En,
    input  logic [TS_W-1:0]                       Nus,
    input  logic [NCH-1:0]                        EVT,
    output logic [TS_W-1:0]                       TS_DATA,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] TS_CH,
    output logic                                  TS_VALID,
    input  logic                                  TS_READY,
    output logic [$clog2(DEPTH):0]                FIFO_CNT,
    output logic [NCH-1:0]                        DROP
`ifdef TS_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]                 DROP_CNT
`endif
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q, sync_d;
    logic [NCH-1:0]  prev_q, prev_d;
    logic [NCH-1:0]  evt_rise;
    logic [NCH-1:0]  pend_q, pend_d;
    logic [TS_W-1:0] cap_q [NCH];
    logic [TS_W-1:0] cap_d [NCH];
    logic [NCH-1:0]  drop_q, drop_d;
    logic [NCH-1:0]  wr_grant;
    logic [CHW-1:0]  sel;
    logic            any_pend, push, pop, full, empty;
    ts_entry_t       wr_entry, rd_entry;
    logic            unused_ch;

    // Synchronizers run regardless of En so enabling never fakes an edge.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], EVT};
        prev_d   = sync_q[SYNC_STAGES-1];
        evt_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Lowest-index pending channel wins the single write slot.
    always_comb begin
        sel      = '0;
        any_pend = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel      = CHW'(i);
                any_pend = 1'b1;
            end
        end
        pop      = TS_VALID && TS_READY;
        push     = any_pend && (!full || pop);
        wr_grant = '0;
        if (push) begin
            wr_grant[sel] = 1'b1;
        end
        wr_entry    = '0;
        wr_entry.ch = CH_W_MAX'(sel);
        wr_entry.ts = cap_q[sel];
    end

    // An edge landing in the cycle its old entry is written re-arms the channel.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pend_d[i] = pend_q[i];
            cap_d[i]  = cap_q[i];
            drop_d[i] = 1'b0;
            if (!En) begin
                pend_d[i] = 1'b0;
            end else if (evt_rise[i]) begin
                if (!pend_q[i] || wr_grant[i]) begin
                    pend_d[i] = 1'b1;
                    cap_d[i]  = Nus;
                end else begin
                    drop_d[i] = 1'b1;
                end
            end else if (wr_grant[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            prev_q <= '0;
            pend_q <= '0;
            drop_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cap_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
            for (int i = 0; i < NCH; i++) begin
                cap_q[i] <= cap_d[i];
            end
        end
    end

    ts_fifo #(
        .W     ($bits(ts_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (rd_entry),
        .full  (full),
        .empty (empty),
        .count (FIFO_CNT)
    );

    assign TS_VALID  = !empty;
    assign TS_DATA   = rd_entry.ts;
    assign TS_CH     = rd_entry.ch[CHW-1:0];
    assign DROP      = drop_q;
    assign unused_ch = ^rd_entry.ch;

`ifdef TS_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] dcnt_q, dcnt_d;

    // Counts cycles with any drop, so coincident drops count once.
    always_comb begin
        dcnt_d = dcnt_q;
        if ((|drop_d) && (dcnt_q != '1)) begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

    assign DROP_CNT = dcnt_q;
`endif

endmodule

// File: tb/tb_event_timestamp_capture.sv
// Directed and randomized checks of event_timestamp_capture against a queue model.
module tb_event_timestamp_capture;
    localparam int NCH   = 4;
    localparam int DEPTH = 8;
    localparam int SS    = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic            En;
    logic [63:0]     Nus;
    logic [NCH-1:0]  EVT;
    logic [63:0]     TS_DATA;
    logic [1:0]      TS_CH;
    logic            TS_VALID;
    logic            TS_READY;
    logic [3:0]      FIFO_CNT;
    logic [NCH-1:0]  DROP;
`ifdef TS_DROP_CNT_EN
    logic [15:0]     DROP_CNT;
`endif

    event_timestamp_capture #(.NCH(NCH), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .En       (En),
        .Nus      (Nus),
        .EVT      (EVT),
        .TS_DATA  (TS_DATA),
        .TS_CH    (TS_CH),
        .TS_VALID (TS_VALID),
        .TS_READY (TS_READY),
        .FIFO_CNT (FIFO_CNT),
        .DROP     (DROP)
`ifdef TS_DROP_CNT_EN
        ,
        .DROP_CNT (DROP_CNT)
`endif
    );

    always #10 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_ts_q[$];
    logic [1:0]  exp_ch_q[$];
    int          drop_seen [NCH];
    int          pops = 0;
    logic        stalled = 1'b0;
    logic [63:0] last_data;
    logic [1:0]  last_ch;
    logic        rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_ready) TS_READY = ($urandom_range(0, 3) != 0);
    endtask

    task automatic expect_mask(input logic [NCH-1:0] mask, input logic [63:0] t);
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                exp_ch_q.push_back(2'(c));
                exp_ts_q.push_back(t);
            end
        end
    endtask

    task automatic fire(input logic [NCH-1:0] mask, input logic [63:0] t, input int hi, input int lo);
        Nus = t;
        EVT = mask;
        repeat (hi) tick();
        EVT = '0;
        repeat (lo) tick();
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        TS_READY = 1'b1;
        while ((exp_ts_q.size() != 0 || TS_VALID) && n < bound) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check({tag, "_left"}, 64'(exp_ts_q.size()), 64'd0);
        check({tag, "_cnt"}, 64'(FIFO_CNT), 64'd0);
    endtask

    function automatic int total_drops();
        int s = 0;
        for (int c = 0; c < NCH; c++) s += drop_seen[c];
        return s;
    endfunction

    // Output monitor: pops compared against the expected queue, head hold under stall.
    always @(negedge CLK) begin
        if (RST !== 1'b0) begin
            stalled <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) if (DROP[c]) drop_seen[c]++;
            if (stalled) begin
                check("hold_data", TS_DATA, last_data);
                check("hold_ch", 64'(TS_CH), 64'(last_ch));
            end
            if (TS_VALID && TS_READY) begin
                if (exp_ts_q.size() == 0) begin
                    check("pop_unexpected", 64'(TS_VALID), 64'd0);
                end else begin
                    check("pop_ch", 64'(TS_CH), 64'(exp_ch_q.pop_front()));
                    check("pop_ts", TS_DATA, exp_ts_q.pop_front());
                    pops++;
                end
            end
            stalled   <= TS_VALID && !TS_READY;
            last_data <= TS_DATA;
            last_ch   <= TS_CH;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int drops_before;
        logic [63:0] t;
        logic [NCH-1:0] mask;

        for (int c = 0; c < NCH; c++) drop_seen[c] = 0;
        RST = 1'b0; En = 1'b0; EVT = '0; Nus = '0; TS_READY = 1'b0;
        #1 RST = 1'b1;
        repeat (3) tick();

        // Reset values
        check("rst_valid", 64'(TS_VALID), 64'd0);
        check("rst_data", TS_DATA, 64'd0);
        check("rst_ch", 64'(TS_CH), 64'd0);
        check("rst_cnt", 64'(FIFO_CNT), 64'd0);
        check("rst_drop", 64'(DROP), 64'd0);
`ifdef TS_DROP_CNT_EN
        check("rst_dropcnt", 64'(DROP_CNT), 64'd0);
`endif
        RST = 1'b0;
        En  = 1'b1;
        repeat (3) tick();

        // Single event on channel 1
        Nus = 64'd1000;
        EVT = 4'b0010;
        lat = 0;
        while (!TS_VALID && lat < 12) begin
            tick();
            lat++;
        end
        check("single_latency_in_window", 64'((lat >= SS + 1) && (lat <= SS + 2)), 64'd1);
        check("single_ch", 64'(TS_CH), 64'd1);
        check("single_ts", TS_DATA, 64'd1000);
        check("single_cnt", 64'(FIFO_CNT), 64'd1);
        repeat (3) tick();
        EVT = '0;
        repeat (4) tick();
        expect_mask(4'b0010, 64'd1000);
        drain("single", 20);

        // Simultaneous edges on ch0 and ch3
        TS_READY = 1'b0;
        expect_mask(4'b1001, 64'd5000);
        fire(4'b1001, 64'd5000, 4, 4);
        check("simul_cnt", 64'(FIFO_CNT), 64'd2);
        drain("simul", 20);

        // Overflow on ch2: 8 queued, 9th pending, 10th dropped
        TS_READY = 1'b0;
        drops_before = drop_seen[2];
        for (int e = 0; e < 10; e++) begin
            t = {$urandom, $urandom};
            if (e < 9) expect_mask(4'b0100, t);
            fire(4'b0100, t, 10, 90);
        end
        check("ovf_cnt", 64'(FIFO_CNT), 64'd8);
        check("ovf_drop_ch2", 64'(drop_seen[2] - drops_before), 64'd1);
        check("ovf_drop_total", 64'(total_drops()), 64'd1);
`ifdef TS_DROP_CNT_EN
        check("ovf_dropcnt", 64'(DROP_CNT), 64'd1);
`endif
        drain("ovf", 60);

        // Backpressure: ready toggles every cycle with 4 entries queued
        TS_READY = 1'b0;
        for (int e = 0; e < 4; e++) begin
            t = {$urandom, $urandom};
            mask = 4'(1 << $urandom_range(0, NCH - 1));
            expect_mask(mask, t);
            fire(mask, t, 4, 4);
        end
        check("bp_cnt_full4", 64'(FIFO_CNT), 64'd4);
        for (int n = 0; n < 60 && exp_ts_q.size() != 0; n++) begin
            TS_READY = ~TS_READY;
            tick();
        end
        TS_READY = 1'b0;
        tick();
        check("bp_left", 64'(exp_ts_q.size()), 64'd0);
        check("bp_cnt_zero", 64'(FIFO_CNT), 64'd0);

        // En low: edges ignored, no false edge when En rises with EVT high
        TS_READY = 1'b1;
        En = 1'b0;
        drops_before = total_drops();
        fire(4'b1111, 64'd77, 5, 5);
        fire(4'b0110, 64'd88, 5, 5);
        check("enlow_cnt", 64'(FIFO_CNT), 64'd0);
        EVT = 4'b1011;
        repeat (5) tick();
        En = 1'b1;
        repeat (10) tick();
        check("enrise_cnt", 64'(FIFO_CNT), 64'd0);
        check("enrise_valid", 64'(TS_VALID), 64'd0);
        EVT = '0;
        repeat (5) tick();
        check("enlow_nodrop", 64'(total_drops()), 64'(drops_before));

        // En low discards a stamp still pending behind a full queue
        TS_READY = 1'b0;
        for (int e = 0; e < 8; e++) begin
            t = {$urandom, $urandom};
            expect_mask(4'b0001, t);
            fire(4'b0001, t, 4, 4);
        end
        fire(4'b0010, 64'd4242, 4, 4);
        En = 1'b0;
        repeat (3) tick();
        En = 1'b1;
        repeat (3) tick();
        check("enclr_cnt", 64'(FIFO_CNT), 64'd8);
        drain("enclr", 40);
        check("enclr_nodrop", 64'(total_drops()), 64'(drops_before));

        // Randomized traffic with random reader stalls
        rand_ready = 1'b1;
        for (int e = 0; e < 40; e++) begin
            t = {$urandom, $urandom};
            mask = 4'($urandom_range(1, 15));
            expect_mask(mask, t);
            fire(mask, t, $urandom_range(3, 6), $urandom_range(6, 12));
        end
        rand_ready = 1'b0;
        drain("rand", 80);
        check("rand_nodrop", 64'(total_drops()), 64'(drops_before));

        // Reset mid-stream with a full queue and two pending channels
        TS_READY = 1'b0;
        for (int e = 0; e < 8; e++) fire(4'b0001, {$urandom, $urandom}, 4, 4);
        fire(4'b0110, 64'd9999, 4, 4);
        check("mid_cnt_full", 64'(FIFO_CNT), 64'd8);
        RST = 1'b1;
        exp_ts_q.delete();
        exp_ch_q.delete();
        #1;
        check("mid_rst_valid", 64'(TS_VALID), 64'd0);
        check("mid_rst_cnt", 64'(FIFO_CNT), 64'd0);
        check("mid_rst_data", TS_DATA, 64'd0);
`ifdef TS_DROP_CNT_EN
        check("mid_rst_dropcnt", 64'(DROP_CNT), 64'd0);
`endif
        repeat (2) tick();
        RST = 1'b0;
        TS_READY = 1'b1;
        repeat (30) tick();
        check("post_rst_cnt", 64'(FIFO_CNT), 64'd0);
        check("post_rst_valid", 64'(TS_VALID), 64'd0);
        check("final_drop_total", 64'(total_drops()), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
